ahb_sram_slave: RTL and testbench

AHB responder that terminates single and burst transfers into an on-chip word-organised SRAM. It is the slave-side counterpart of the team's AHB master and sits behind the address decoder on the same HCLK domain. It handles the pipelined address/data phases, byte/halfword/word writes, optional wait-state insertion and the two-cycle ERROR response.

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_slv_mem.sv | 26 ++
 rtl/ahb_sram_slave.sv | 122 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the SRAM responder: transfer/response encodings,
// data-phase state type and the little-endian byte-lane decode.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    D_IDLE,
    D_WAIT,
    D_DONE,
    D_ERR1,
    D_ERR2
  } ahb_slv_state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << a;
      HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised SRAM behind the AHB responder: byte-enable synchronous write,
// combinational read so a read data phase sees a write committed one edge earlier.
module ahb_slv_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB responder terminating single/burst transfers into on-chip SRAM.
// Define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles per non-error data phase.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK_i,
  input  logic        HRESET_i,
  input  logic        HSEL_i,
  input  logic [31:0] HADDR_i,
  input  logic [1:0]  HTRANS_i,
  input  logic        HWRITE_i,
  input  logic [2:0]  HSIZE_i,
  input  logic [2:0]  HBURST_i,
  input  logic [31:0] HWDATA_i,
  input  logic        HREADY_i,
  output logic        HREADYOUT_o,
  output logic [1:0]  HRESP_o,
  output logic [31:0] HRDATA_o
);

  htrans_t           trans;
  logic              accept, take, acc_err;
  logic [3:0]        acc_lanes;
  ahb_slv_state_t    state_q, accept_state;
  logic              hreadyout_q;
  logic [1:0]        hresp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [3:0]        lanes_q;
  logic [31:0]       mem_rdata;
  logic              unused_cfg;
`ifdef AHB_SLV_WAIT_EN
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  logic [CNT_W-1:0] cnt_q;
`endif

  assign trans     = htrans_t'(HTRANS_i);
  assign accept    = HSEL_i && HREADY_i && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
  assign take      = accept && (state_q inside {D_IDLE, D_DONE, D_ERR2});
  assign acc_err   = (HSIZE_i > HSIZE_WORD)
                  || (HSIZE_i == HSIZE_HALF && HADDR_i[0])
                  || (HSIZE_i == HSIZE_WORD && HADDR_i[1:0] != 2'b00)
                  || (HADDR_i[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
  assign acc_lanes = lane_mask(HSIZE_i, HADDR_i[1:0]);

  // Burst type carries no meaning here: every beat is decoded on its own.
  assign unused_cfg = ^{HBURST_i, (WAIT_STATES != 0)};

  always_comb begin
    accept_state = D_IDLE;
    if (take) begin
      if (acc_err) accept_state = D_ERR1;
`ifdef AHB_SLV_WAIT_EN
      else if (WAIT_STATES > 0) accept_state = D_WAIT;
`endif
      else accept_state = D_DONE;
    end
  end

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      state_q     <= D_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      addr_q      <= '0;
      write_q     <= 1'b0;
      lanes_q     <= '0;
`ifdef AHB_SLV_WAIT_EN
      cnt_q       <= '0;
`endif
    end else begin
      if (take) begin
        addr_q  <= HADDR_i[ADDR_W+1:2];
        write_q <= HWRITE_i;
        lanes_q <= acc_lanes;
      end
      case (state_q)
`ifdef AHB_SLV_WAIT_EN
        D_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= D_DONE;
            hreadyout_q <= 1'b1;
          end
        end
`endif
        D_ERR1: begin
          state_q     <= D_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= accept_state;
          hreadyout_q <= (accept_state == D_DONE) || (accept_state == D_IDLE);
          hresp_q     <= (accept_state == D_ERR1) ? HRESP_ERROR : HRESP_OKAY;
`ifdef AHB_SLV_WAIT_EN
          if (take) cnt_q <= CNT_W'(WAIT_STATES);
`endif
        end
      endcase
    end
  end

  // Errored beats never reach D_DONE, so they can neither write nor return data.
  ahb_slv_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk_i   (HCLK_i),
    .we_i    (state_q == D_DONE && write_q),
    .be_i    (lanes_q),
    .addr_i  (addr_q),
    .wdata_i (HWDATA_i),
    .rdata_o (mem_rdata)
  );

  assign HREADYOUT_o = hreadyout_q;
  assign HRESP_o     = hresp_q;
  assign HRDATA_o    = (state_q == D_DONE && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: pipelined AHB master driving directed and random beats,
// checked against a byte-level memory/response model.
module tb_ahb_sram_slave;

`ifdef AHB_SLV_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, hready, hreadyout;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut (
    .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(hsel), .HADDR_i(haddr), .HTRANS_i(htrans),
    .HWRITE_i(hwrite), .HSIZE_i(hsize), .HBURST_i(hburst), .HWDATA_i(hwdata),
    .HREADY_i(hready), .HREADYOUT_o(hreadyout), .HRESP_o(hresp), .HRDATA_o(hrdata)
  );

  typedef struct {
    logic        act;
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mref [1024];
  logic [31:0] last_rd;
  beat_t       bq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(beat_t b);
    if (b.size > 2) return 1'b1;
    if (b.addr % (32'd1 << b.size) != 0) return 1'b1;
    if (b.addr / 4096 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_idx(beat_t b);
    return int'((b.addr % 4096) / 4);
  endfunction

  function automatic void m_write(beat_t b);
    int idx = m_idx(b);
    int off = int'(b.addr % 4);
    for (int k = 0; k < (1 << b.size); k++)
      mref[idx][8*(off+k) +: 8] = b.wdata[8*(off+k) +: 8];
  endfunction

  function automatic void add_xfer(input logic [31:0] a, input logic wr,
                                   input logic [2:0] sz, input logic [31:0] wd);
    beat_t b;
    b.act = 1'b1; b.sel = 1'b1; b.trans = (bq.size() == 0) ? 2'b10 : 2'b11;
    b.addr = a; b.wr = wr; b.size = sz; b.wdata = wd;
    bq.push_back(b);
  endfunction

  function automatic void add_gap(input int kind);
    beat_t b;
    b.act = 1'b0; b.sel = (kind != 2); b.trans = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
    b.addr = $urandom; b.wr = 1'($urandom); b.size = 3'd2; b.wdata = $urandom;
    bq.push_back(b);
  endfunction

  task automatic drive(input beat_t b);
    hsel = b.sel; haddr = b.addr; htrans = b.trans; hwrite = b.wr; hsize = b.size; hburst = 3'b011;
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'b000;
  endtask

  // Entered at a negedge with the bus idle and the DUT ready.
  task automatic run_queue();
    int   pend = -1, dph = -1, nxt = 0, stalls = 0, guard = 0;
    logic hr_prev = 1'b1;
    bit   e;
    logic [31:0] exp_rd;
    forever begin
      if (pend < 0) begin
        if (nxt < bq.size()) begin drive(bq[nxt]); pend = nxt; nxt++; end
        else drive_idle();
      end
      @(negedge clk);
      guard++;
      if (hr_prev) begin
        dph = (pend >= 0 && bq[pend].act) ? pend : -1;
        pend = -1; stalls = 0;
        hwdata = (dph >= 0) ? bq[dph].wdata : $urandom;
      end
      if (dph >= 0) begin
        e = m_err(bq[dph]);
        if (!hreadyout) begin
          stalls++;
          chk("stall_resp", {30'd0, hresp}, e ? 32'd1 : 32'd0);
          chk("stall_rdata", hrdata, 32'd0);
        end else begin
          exp_rd = (!e && !bq[dph].wr) ? mref[m_idx(bq[dph])] : 32'd0;
          chk("done_stalls", stalls, e ? 32'd1 : W);
          chk("done_resp", {30'd0, hresp}, e ? 32'd1 : 32'd0);
          chk("done_rdata", hrdata, exp_rd);
          if (!e && !bq[dph].wr) last_rd = hrdata;
          if (!e && bq[dph].wr) m_write(bq[dph]);
        end
      end else begin
        chk("idle_ready", {31'd0, hreadyout}, 32'd1);
        chk("idle_resp", {30'd0, hresp}, 32'd0);
        chk("idle_rdata", hrdata, 32'd0);
      end
      hr_prev = hreadyout;
      hready  = hreadyout;
      if (nxt >= bq.size() && pend < 0 && (dph < 0 || hreadyout)) break;
      if (guard > 2000) begin
        chk("run_timeout", guard, 32'd0);
        break;
      end
    end
    drive_idle();
    bq.delete();
  endtask

  initial begin
    beat_t b;
    rst = 1'b1; hready = 1'b1; hwdata = 32'h0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, hreadyout}, 32'd1);
    chk("reset_resp", {30'd0, hresp}, 32'd0);
    chk("reset_rdata", hrdata, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, hreadyout}, 32'd1);
      chk("idle_resp", {30'd0, hresp}, 32'd0);
      chk("idle_rdata", hrdata, 32'd0);
    end

    for (int i = 0; i < 32; i++) add_xfer(32'(i * 4), 1'b1, 3'd2, 32'h0);
    run_queue();

    add_xfer(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
    add_xfer(32'h10, 1'b0, 3'd2, 32'h0);
    last_rd = 32'h0;
    run_queue();
    chk("raw_read", last_rd, 32'hDEAD_BEEF);

    add_xfer(32'h20, 1'b1, 3'd2, 32'h1122_3344);
    add_xfer(32'h22, 1'b1, 3'd0, 32'h00AA_0000);
    add_xfer(32'h20, 1'b0, 3'd2, 32'h0);
    run_queue();
    chk("byte_lane2", last_rd, 32'h11AA_3344);

    add_xfer(32'h06, 1'b0, 3'd2, 32'h0);
    add_xfer(32'h1000, 1'b1, 3'd2, 32'hFFFF_FFFF);
    add_xfer(32'h12, 1'b1, 3'd2, 32'hFFFF_FFFF);
    add_xfer(32'h13, 1'b1, 3'd1, 32'hFFFF_FFFF);
    add_xfer(32'h00, 1'b0, 3'd2, 32'h0);
    run_queue();
    chk("err_no_write0", last_rd, 32'h0);
    add_xfer(32'h10, 1'b0, 3'd2, 32'h0);
    run_queue();
    chk("err_no_write10", last_rd, 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) add_xfer(32'h40 + 32'(4 * i), 1'b1, 3'd2, 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) add_xfer(32'h40 + 32'(4 * i), 1'b0, 3'd2, 32'h0);
    run_queue();
    chk("incr4_last", last_rd, 32'hA000_0003);

    // Abort a write to 0x50 mid data phase with an asynchronous reset.
    b.act = 1'b1; b.sel = 1'b1; b.trans = 2'b10; b.addr = 32'h50; b.wr = 1'b1;
    b.size = 3'd2; b.wdata = 32'h5555_AAAA;
    drive(b);
    @(negedge clk);
    hwdata = 32'h5555_AAAA;
`ifdef AHB_SLV_WAIT_EN
    chk("rst_pre_wait", {31'd0, hreadyout}, 32'd0);
`endif
    #2 rst = 1'b1;
    drive_idle();
    #1;
    chk("rst_async_ready", {31'd0, hreadyout}, 32'd1);
    chk("rst_async_resp", {30'd0, hresp}, 32'd0);
    chk("rst_async_rdata", hrdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; hready = 1'b1;
    add_xfer(32'h50, 1'b0, 3'd2, 32'h0);
    last_rd = 32'hFFFF_FFFF;
    run_queue();
    chk("rst_abort", last_rd, 32'h0);

    for (int batch = 0; batch < 30; batch++) begin
      for (int n = 0; n < 10; n++) begin
        int          r = $urandom_range(0, 99);
        logic [2:0]  sz;
        logic [31:0] off, hi, a;
        if (r < 15) add_gap($urandom_range(0, 2));
        else begin
          sz  = ($urandom_range(0, 99) < 8) ? 3'd3 : 3'($urandom_range(0, 2));
          off = (sz == 3'd0) ? $urandom_range(0, 3) : (sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
          if ($urandom_range(0, 99) < 10) off = $urandom_range(0, 3);
          hi  = ($urandom_range(0, 99) < 7) ? $urandom_range(1, 15) : 0;
          a   = hi * 4096 + $urandom_range(0, 31) * 4 + off;
          add_xfer(a, 1'($urandom), sz, $urandom);
        end
      end
      run_queue();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
